// File: rtl/mdio_master.sv
// Clause-22 MDIO management master.
// Turns one latched register request into a preamble/ST/OP/PHYAD/REGAD/TA/DATA
// frame on MDC/MDIO and returns a one-cycle response pulse when the frame ends.
module mdio_master #(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        ETH_REFCLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [4:0]  REQ_PHYAD,
  input  logic [4:0]  REQ_REGAD,
  input  logic [15:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic        MDIO_CLK,
  output logic        MDIO_DATA_O,
  output logic        MDIO_DATA_OE,
  input  logic        MDIO_DATA_I
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA
  } state_t;

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      SLOT_TA   = 6'(PREAMBLE_LEN + 14);
  localparam logic [5:0]      SLOT_TA2  = 6'(PREAMBLE_LEN + 15);
  localparam logic [5:0]      SLOT_DATA = 6'(PREAMBLE_LEN + 16);
  localparam logic [5:0]      SLOT_LAST = 6'(PREAMBLE_LEN + 31);

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic               r_high;
  logic               r_lead;
  logic [5:0]         r_slot;
  logic               r_write;
  logic [31:0]        r_frame;
  logic [15:0]        r_shift;
  logic               r_ta_err;
  logic               r_rsp_valid;
  logic [15:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_mdc;
  logic               r_mdo;
  logic               r_oe;

  logic [5:0]         w_nxt_slot;
  logic               w_nxt_framed;
  state_t             w_nxt_state;
  logic               w_nxt_oe;
  logic               w_nxt_bit;

  assign REQ_READY    = (r_state == IDLE);
  assign BUSY         = (r_state != IDLE);
  assign RSP_VALID    = r_rsp_valid;
  assign RSP_RDATA    = r_rsp_rdata;
  assign RSP_ERR      = r_rsp_err;
  assign MDIO_CLK     = r_mdc;
  assign MDIO_DATA_O  = r_mdo;
  assign MDIO_DATA_OE = r_oe;

  // Pad values and state for the slot that starts at the next slot boundary.
  // The first slot after acceptance is slot 0, reached via a one-cycle lead-in.
  always_comb begin
    w_nxt_slot   = r_lead ? '0 : r_slot + 6'd1;
    // slot >= PREAMBLE_LEN, written as slot+1 > PREAMBLE_LEN so it stays
    // meaningful when the preamble is suppressed
    w_nxt_framed = ({1'b0, w_nxt_slot} + 7'd1) > 7'(PREAMBLE_LEN);
    w_nxt_state  = DATA;
    if (!w_nxt_framed)
      w_nxt_state = PRE;
    else if (w_nxt_slot < SLOT_TA)
      w_nxt_state = HDR;
    else if (w_nxt_slot < SLOT_DATA)
      w_nxt_state = TA;
    w_nxt_oe  = !w_nxt_framed || r_write || (w_nxt_slot < SLOT_TA);
    w_nxt_bit = (w_nxt_framed && w_nxt_oe) ? r_frame[31] : 1'b1;
  end

  // Frame sequencer: request latch, MDC divider, slot stepping, read capture.
  always_ff @(posedge ETH_REFCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_high      <= 1'b0;
      r_lead      <= 1'b0;
      r_slot      <= '0;
      r_write     <= 1'b0;
      r_frame     <= '0;
      r_shift     <= '0;
      r_ta_err    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mdc       <= 1'b0;
      r_mdo       <= 1'b1;
      r_oe        <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (REQ_VALID) begin
            r_write  <= REQ_WRITE;
            r_frame  <= {2'b01, REQ_WRITE ? 2'b01 : 2'b10, REQ_PHYAD, REQ_REGAD,
                         REQ_WRITE ? 2'b10 : 2'b11, REQ_WRITE ? REQ_WDATA : 16'hFFFF};
            r_state  <= (PREAMBLE_LEN > 0) ? PRE : HDR;
            r_lead   <= 1'b1;
            r_ta_err <= 1'b0;
            r_shift  <= '0;
          end
        end
        default: begin
          if (r_lead || (r_high && r_div == DIV_LAST)) begin
            if (!r_lead && r_slot == SLOT_LAST) begin
              r_state     <= IDLE;
              r_mdc       <= 1'b0;
              r_oe        <= 1'b0;
              r_mdo       <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= r_write ? '0 : r_shift;
              r_rsp_err   <= r_write ? 1'b0 : r_ta_err;
            end else begin
              r_lead  <= 1'b0;
              r_slot  <= w_nxt_slot;
              r_state <= w_nxt_state;
              r_mdc   <= 1'b0;
              r_high  <= 1'b0;
              r_div   <= '0;
              r_oe    <= w_nxt_oe;
              r_mdo   <= w_nxt_bit;
              if (w_nxt_framed)
                r_frame <= {r_frame[30:0], 1'b0};
            end
          end else if (!r_high && r_div == DIV_LAST) begin
            r_mdc  <= 1'b1;
            r_high <= 1'b1;
            r_div  <= '0;
            if (!r_write) begin
              if (r_slot == SLOT_TA2)
                r_ta_err <= MDIO_DATA_I;
              if (r_state == DATA)
                r_shift <= {r_shift[14:0], MDIO_DATA_I};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
